// File: rtl/ahb_wait_slave.sv
// ahb_wait_slave: AHB-Lite word memory slave with fixed wait-state insertion,
// two-cycle ERROR responses and pipelined back-to-back transfers.
module ahb_wait_slave #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic        hwrite,
    input  logic [1:0]  htrans,
    input  logic        hready_in,
    output logic        hready,
    output logic        hresp,
    output logic [31:0] hrdata
);
    localparam int AW = $clog2(MEM_DEPTH);
    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
    state_t        state, state_nx;
    logic [2:0]    cnt, cnt_nx;
    logic [AW-1:0] idx_q;
    logic [1:0]    lane_q;
    logic [2:0]    size_q;
    logic          write_q;
    logic          accept, bad;
    logic [3:0]    be;
    logic [31:0]   mem [MEM_DEPTH];
    logic          unused_hburst;
    assign unused_hburst = ^hburst;
    // Only take a new address phase while our own data phase is completing.
    assign accept = hsel && htrans[1] && hready_in && hready;
    assign bad = hsize > 3'd2 || (hsize == 3'd1 && haddr[0]) ||
                 (hsize == 3'd2 && haddr[1:0] != 2'b00) || haddr[31:2] >= 30'(MEM_DEPTH);
    assign be = size_q == 3'd0 ? 4'b0001 << lane_q :
                size_q == 3'd1 ? (lane_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                idx_q   <= haddr[AW+1:2];
                lane_q  <= haddr[1:0];
                size_q  <= hsize;
                write_q <= hwrite;
            end
        end
    end
    always_comb begin
        state_nx = accept ? (bad ? ERR1 : (WAIT_STATES == 0 ? DATA : WAIT)) :
                   state == WAIT ? (cnt <= 3'd1 ? DATA : WAIT) :
                   state == ERR1 ? ERR2 : IDLE;
        cnt_nx   = accept ? 3'(WAIT_STATES) : state == WAIT ? cnt - 3'd1 : cnt;
    end
    always_comb begin
        hready = !(state == WAIT || state == ERR1);
        hresp  = state == ERR1 || state == ERR2;
        hrdata = (state == DATA && !write_q) ? mem[idx_q] : 32'h0;
    end
    // Async reset drops state out of DATA before this edge, so aborted writes never land.
    always_ff @(posedge clk) begin
        if (state == DATA && write_q)
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
    end
endmodule

// File: tb/tb_ahb_wait_slave.sv
// tb_ahb_wait_slave: three slaves (0, 1 and 3 wait states) driven by a pipelined
// AHB master and compared against a byte-addressed reference memory.
module tb_ahb_wait_slave;
    localparam int DEPTH = 256;
    localparam int MAXB = 128;
    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wdata;
    } beat_t;
    logic clk = 1'b0;
    logic hresetn = 1'b0;
    logic        hsel_b [3];
    logic [31:0] haddr_b [3];
    logic [31:0] hwdata_b [3];
    logic [2:0]  hsize_b [3];
    logic [2:0]  hburst_b [3];
    logic        hwrite_b [3];
    logic [1:0]  htrans_b [3];
    logic        hready_b [3];
    logic        hresp_b [3];
    logic [31:0] hrdata_b [3];
    int errors = 0;
    int checks = 0;
    beat_t bq[$];
    int          exp_wait [MAXB];
    logic        exp_resp [MAXB];
    logic        exp_chk  [MAXB];
    logic [31:0] exp_data [MAXB];
    int          obs_wait [MAXB];
    logic        obs_rf   [MAXB];
    logic        obs_rl   [MAXB];
    logic        obs_nz   [MAXB];
    logic [31:0] obs_data [MAXB];
    logic [7:0]  mb [3][DEPTH*4];
    always #5 clk = ~clk;
    ahb_wait_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .hresetn(hresetn), .hsel(hsel_b[0]), .haddr(haddr_b[0]), .hwdata(hwdata_b[0]),
        .hsize(hsize_b[0]), .hburst(hburst_b[0]), .hwrite(hwrite_b[0]), .htrans(htrans_b[0]),
        .hready_in(hready_b[0]), .hready(hready_b[0]), .hresp(hresp_b[0]), .hrdata(hrdata_b[0]));
    ahb_wait_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .hresetn(hresetn), .hsel(hsel_b[1]), .haddr(haddr_b[1]), .hwdata(hwdata_b[1]),
        .hsize(hsize_b[1]), .hburst(hburst_b[1]), .hwrite(hwrite_b[1]), .htrans(htrans_b[1]),
        .hready_in(hready_b[1]), .hready(hready_b[1]), .hresp(hresp_b[1]), .hrdata(hrdata_b[1]));
    ahb_wait_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .hresetn(hresetn), .hsel(hsel_b[2]), .haddr(haddr_b[2]), .hwdata(hwdata_b[2]),
        .hsize(hsize_b[2]), .hburst(hburst_b[2]), .hwrite(hwrite_b[2]), .htrans(htrans_b[2]),
        .hready_in(hready_b[2]), .hready(hready_b[2]), .hresp(hresp_b[2]), .hrdata(hrdata_b[2]));
    function automatic int ws_of(input int b);
        return b == 0 ? 0 : b == 1 ? 1 : 3;
    endfunction
    // Reference: byte memory updated in bus order; response shape from the transfer rules.
    function automatic void model(input int b, input beat_t t, output int ew, output logic er,
                                  output logic chk, output logic [31:0] ed);
        int nb, w;
        ew = 0; er = 1'b0; chk = 1'b1; ed = 32'h0;
        if (!t.sel || !t.trans[1]) return;
        if (t.size > 3'd2 || (t.size == 3'd1 && t.addr[0]) || (t.size == 3'd2 && t.addr[1:0] != 2'b00) ||
            t.addr >= 32'(DEPTH * 4)) begin
            ew = 1; er = 1'b1;
            return;
        end
        ew = ws_of(b);
        nb = 1 << t.size;
        w = int'(t.addr) & ~3;
        if (t.wr) begin
            chk = 1'b0;
            for (int k = 0; k < nb; k++)
                mb[b][int'(t.addr) + k] = t.wdata[8*((int'(t.addr) + k) % 4) +: 8];
        end else
            ed = {mb[b][w+3], mb[b][w+2], mb[b][w+1], mb[b][w]};
    endfunction
    task automatic push(input logic s, input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz,
                        input logic w, input logic [31:0] wd);
        beat_t t;
        t.sel = s; t.trans = tr; t.addr = a; t.size = sz; t.wr = w; t.wdata = wd;
        bq.push_back(t);
    endtask
    task automatic idle_all();
        for (int b = 0; b < 3; b++) begin
            hsel_b[b] = 1'b0; htrans_b[b] = 2'd0; haddr_b[b] = '0; hwdata_b[b] = '0;
            hsize_b[b] = 3'd2; hburst_b[b] = 3'd0; hwrite_b[b] = 1'b0;
        end
    endtask
    // Pipelined master: address phase of beat a overlaps data phase of beat d.
    task automatic run(input int b);
        int n, a, d, bc, cyc;
        n = bq.size();
        for (int i = 0; i < n; i++) begin
            model(b, bq[i], exp_wait[i], exp_resp[i], exp_chk[i], exp_data[i]);
            obs_wait[i] = 0; obs_rf[i] = 1'bx; obs_rl[i] = 1'bx; obs_nz[i] = 1'b0; obs_data[i] = 'x;
        end
        a = 0; d = -1; bc = 0; cyc = 0;
        while ((a < n || d >= 0) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            hsel_b[b]   = a < n ? bq[a].sel : 1'b0;
            htrans_b[b] = a < n ? bq[a].trans : 2'd0;
            haddr_b[b]  = a < n ? bq[a].addr : 32'h0;
            hsize_b[b]  = a < n ? bq[a].size : 3'd2;
            hwrite_b[b] = a < n ? bq[a].wr : 1'b0;
            hburst_b[b] = 3'd1;
            hwdata_b[b] = d >= 0 ? bq[d].wdata : 32'h0;
            if (d >= 0) begin
                if (bc == 0) obs_rf[d] = hresp_b[b];
                if (!hready_b[b]) begin
                    obs_wait[d]++;
                    if (hrdata_b[b] !== 32'h0) obs_nz[d] = 1'b1;
                end else begin
                    obs_rl[d] = hresp_b[b];
                    obs_data[d] = hrdata_b[b];
                end
                bc++;
            end
            if (hready_b[b]) begin
                d = a < n ? a : -1;
                if (a < n) a++;
                bc = 0;
            end
        end
        checks++;
        if (a < n || d >= 0) begin
            errors++;
            $display("FAIL run_timeout bus%0d: stuck at beat %0d of %0d, required completion", b, d, n);
        end
    endtask
    task automatic test_reset();
        idle_all();
        repeat (2) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            checks++;
            if ({hready_b[b], hresp_b[b]} !== 2'b10 || hrdata_b[b] !== 32'h0) begin
                errors++;
                $display("FAIL reset_out bus%0d: got %b/%b/%h want 1/0/0", b, hready_b[b], hresp_b[b], hrdata_b[b]);
            end
        end
        hresetn = 1'b1;
        hsel_b[1] = 1'b1; htrans_b[1] = 2'd2; haddr_b[1] = 32'h0; hsize_b[1] = 3'd2;
        @(negedge clk);
        idle_all();
        checks++;
        if (hready_b[1] !== 1'b0) begin
            errors++;
            $display("FAIL first_accept: hready got %b want 0", hready_b[1]);
        end
        @(negedge clk);
        checks++;
        if (hready_b[1] !== 1'b1 || hresp_b[1] !== 1'b0) begin
            errors++;
            $display("FAIL first_data: got %b/%b want 1/0", hready_b[1], hresp_b[1]);
        end
    endtask
    task automatic test_fill();
        for (int b = 0; b < 3; b++) begin
            bq.delete();
            for (int w = 0; w < 64; w++) push(1'b1, 2'd2, 32'(w * 4), 3'd2, 1'b1, $urandom);
            run(b);
            foreach (bq[i]) begin
                checks++;
                if (obs_wait[i] !== exp_wait[i] || obs_rf[i] !== exp_resp[i] || obs_rl[i] !== exp_resp[i]) begin
                    errors++;
                    $display("FAIL fill_resp bus%0d beat%0d: got wait=%0d resp=%b%b want wait=%0d resp=%b", b, i, obs_wait[i], obs_rf[i], obs_rl[i], exp_wait[i], exp_resp[i]);
                end
            end
        end
    endtask
    task automatic test_basic();
        bq.delete();
        push(1'b1, 2'd2, 32'h10, 3'd2, 1'b1, 32'hDEADBEEF);
        push(1'b1, 2'd2, 32'h10, 3'd2, 1'b0, 32'h0);
        run(1);
        foreach (bq[i]) begin
            checks++;
            if (obs_wait[i] !== exp_wait[i] || obs_rf[i] !== exp_resp[i] || obs_rl[i] !== exp_resp[i]) begin
                errors++;
                $display("FAIL basic_resp beat%0d: got wait=%0d resp=%b%b want wait=%0d resp=%b", i, obs_wait[i], obs_rf[i], obs_rl[i], exp_wait[i], exp_resp[i]);
            end
            checks++;
            if ((exp_chk[i] && obs_data[i] !== exp_data[i]) || obs_nz[i]) begin
                errors++;
                $display("FAIL basic_data beat%0d: got %h (stall nonzero=%b) want %h", i, obs_data[i], obs_nz[i], exp_data[i]);
            end
        end
        checks++;
        if (obs_wait[0] !== 1 || obs_data[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_fixed: got wait=%0d data=%h want 1/deadbeef", obs_wait[0], obs_data[1]);
        end
    endtask
    task automatic test_lanes();
        bq.delete();
        push(1'b1, 2'd2, 32'h13, 3'd0, 1'b1, 32'hAA000000);
        push(1'b1, 2'd2, 32'h10, 3'd1, 1'b1, 32'h00001234);
        push(1'b1, 2'd2, 32'h10, 3'd2, 1'b0, 32'h0);
        push(1'b1, 2'd2, 32'h2A, 3'd1, 1'b1, 32'h5A5A0000);
        push(1'b1, 2'd2, 32'h29, 3'd0, 1'b1, 32'h0000C300);
        push(1'b1, 2'd3, 32'h28, 3'd0, 1'b0, 32'h0);
        run(1);
        foreach (bq[i]) begin
            checks++;
            if (obs_wait[i] !== exp_wait[i] || obs_rf[i] !== exp_resp[i] || obs_rl[i] !== exp_resp[i]) begin
                errors++;
                $display("FAIL lanes_resp beat%0d: got wait=%0d resp=%b%b want wait=%0d resp=%b", i, obs_wait[i], obs_rf[i], obs_rl[i], exp_wait[i], exp_resp[i]);
            end
            checks++;
            if ((exp_chk[i] && obs_data[i] !== exp_data[i]) || obs_nz[i]) begin
                errors++;
                $display("FAIL lanes_data beat%0d: got %h (stall nonzero=%b) want %h", i, obs_data[i], obs_nz[i], exp_data[i]);
            end
        end
        checks++;
        if (obs_data[2][31:24] !== 8'hAA || obs_data[2][15:0] !== 16'h1234) begin
            errors++;
            $display("FAIL lanes_fixed: got %h want aa??1234", obs_data[2]);
        end
    endtask
    task automatic test_errors();
        bq.delete();
        push(1'b1, 2'd2, 32'h20, 3'd2, 1'b0, 32'h0);
        push(1'b1, 2'd2, 32'h21, 3'd1, 1'b1, 32'hFFFFFFFF);
        push(1'b1, 2'd2, 32'(DEPTH * 4), 3'd2, 1'b1, 32'h01020304);
        push(1'b1, 2'd2, 32'h20, 3'd3, 1'b1, 32'h0BADF00D);
        push(1'b1, 2'd2, 32'h22, 3'd2, 1'b1, 32'h0BADF00D);
        push(1'b1, 2'd2, 32'h80000020, 3'd0, 1'b1, 32'h77777777);
        push(1'b1, 2'd2, 32'h20, 3'd2, 1'b0, 32'h0);
        for (int b = 0; b < 3; b++) begin
            run(b);
            foreach (bq[i]) begin
                checks++;
                if (obs_wait[i] !== exp_wait[i] || obs_rf[i] !== exp_resp[i] || obs_rl[i] !== exp_resp[i]) begin
                    errors++;
                    $display("FAIL err_resp bus%0d beat%0d: got wait=%0d resp=%b%b want wait=%0d resp=%b", b, i, obs_wait[i], obs_rf[i], obs_rl[i], exp_wait[i], exp_resp[i]);
                end
                checks++;
                if ((exp_chk[i] && obs_data[i] !== exp_data[i]) || obs_nz[i]) begin
                    errors++;
                    $display("FAIL err_data bus%0d beat%0d: got %h (stall nonzero=%b) want %h", b, i, obs_data[i], obs_nz[i], exp_data[i]);
                end
            end
        end
    endtask
    task automatic test_back_to_back();
        bq.delete();
        push(1'b1, 2'd2, 32'h40, 3'd2, 1'b1, 32'h55667788);
        push(1'b1, 2'd2, 32'h40, 3'd2, 1'b0, 32'h0);
        push(1'b1, 2'd3, 32'h41, 3'd0, 1'b1, 32'h0000EE00);
        push(1'b1, 2'd3, 32'h40, 3'd0, 1'b0, 32'h0);
        push(1'b1, 2'd3, 32'h46, 3'd1, 1'b1, 32'h99AA0000);
        push(1'b1, 2'd3, 32'h44, 3'd2, 1'b0, 32'h0);
        run(0);
        foreach (bq[i]) begin
            checks++;
            if (obs_wait[i] !== exp_wait[i] || obs_rf[i] !== exp_resp[i] || obs_rl[i] !== exp_resp[i]) begin
                errors++;
                $display("FAIL b2b_resp beat%0d: got wait=%0d resp=%b%b want wait=%0d resp=%b", i, obs_wait[i], obs_rf[i], obs_rl[i], exp_wait[i], exp_resp[i]);
            end
            checks++;
            if ((exp_chk[i] && obs_data[i] !== exp_data[i]) || obs_nz[i]) begin
                errors++;
                $display("FAIL b2b_data beat%0d: got %h (stall nonzero=%b) want %h", i, obs_data[i], obs_nz[i], exp_data[i]);
            end
        end
        checks++;
        if (obs_data[1] !== 32'h55667788) begin
            errors++;
            $display("FAIL b2b_fixed: got %h want 55667788", obs_data[1]);
        end
    endtask
    task automatic test_reset_mid();
        @(negedge clk);
        hsel_b[1] = 1'b1; htrans_b[1] = 2'd2; haddr_b[1] = 32'h80; hsize_b[1] = 3'd2; hwrite_b[1] = 1'b1;
        @(negedge clk);
        hsel_b[1] = 1'b0; htrans_b[1] = 2'd0; hwdata_b[1] = 32'hBAD0BAD0;
        checks++;
        if (hready_b[1] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_wait: hready got %b want 0", hready_b[1]);
        end
        #2 hresetn = 1'b0;
        #1;
        checks++;
        if ({hready_b[1], hresp_b[1]} !== 2'b10 || hrdata_b[1] !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_out: got %b/%b/%h want 1/0/0", hready_b[1], hresp_b[1], hrdata_b[1]);
        end
        @(negedge clk);
        hresetn = 1'b1;
        hsel_b[0] = 1'b1; htrans_b[0] = 2'd2; haddr_b[0] = 32'h84; hsize_b[0] = 3'd2; hwrite_b[0] = 1'b1;
        @(negedge clk);
        hsel_b[0] = 1'b0; htrans_b[0] = 2'd0; hwdata_b[0] = 32'hBAD1BAD1;
        #2 hresetn = 1'b0;
        @(negedge clk);
        hresetn = 1'b1;
        idle_all();
        for (int b = 0; b < 2; b++) begin
            bq.delete();
            push(1'b1, 2'd2, b == 0 ? 32'h84 : 32'h80, 3'd2, 1'b0, 32'h0);
            run(b);
            checks++;
            if (obs_data[0] !== exp_data[0] || obs_wait[0] !== exp_wait[0]) begin
                errors++;
                $display("FAIL rstmid_old bus%0d: got %h wait=%0d want %h wait=%0d", b, obs_data[0], obs_wait[0], exp_data[0], exp_wait[0]);
            end
        end
    endtask
    task automatic test_burst();
        bq.delete();
        push(1'b1, 2'd0, 32'h0, 3'd2, 1'b0, 32'h0);
        push(1'b1, 2'd2, 32'h20, 3'd2, 1'b0, 32'h0);
        push(1'b1, 2'd1, 32'h24, 3'd2, 1'b0, 32'h0);
        push(1'b1, 2'd3, 32'h24, 3'd2, 1'b0, 32'h0);
        push(1'b1, 2'd0, 32'h28, 3'd2, 1'b0, 32'h0);
        push(1'b1, 2'd3, 32'h28, 3'd2, 1'b0, 32'h0);
        push(1'b1, 2'd1, 32'h2C, 3'd2, 1'b0, 32'h0);
        push(1'b1, 2'd1, 32'h2C, 3'd2, 1'b0, 32'h0);
        push(1'b1, 2'd3, 32'h2C, 3'd2, 1'b0, 32'h0);
        run(2);
        foreach (bq[i]) begin
            checks++;
            if (obs_wait[i] !== exp_wait[i] || obs_rf[i] !== exp_resp[i] || obs_rl[i] !== exp_resp[i]) begin
                errors++;
                $display("FAIL burst_resp beat%0d: got wait=%0d resp=%b%b want wait=%0d resp=%b", i, obs_wait[i], obs_rf[i], obs_rl[i], exp_wait[i], exp_resp[i]);
            end
            checks++;
            if ((exp_chk[i] && obs_data[i] !== exp_data[i]) || obs_nz[i]) begin
                errors++;
                $display("FAIL burst_data beat%0d: got %h (stall nonzero=%b) want %h", i, obs_data[i], obs_nz[i], exp_data[i]);
            end
        end
    endtask
    task automatic test_random();
        logic [2:0] sz;
        logic [31:0] a;
        for (int b = 0; b < 3; b++) begin
            bq.delete();
            for (int k = 0; k < 80; k++) begin
                sz = 3'($urandom_range(0, 3));
                a = 32'($urandom_range(0, 255));
                if (sz <= 3'd2 && $urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
                if ($urandom_range(0, 9) == 0) a = a | (32'($urandom_range(1, 8)) << 10);
                push($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), a, sz, 1'($urandom_range(0, 1)), $urandom);
            end
            run(b);
            foreach (bq[i]) begin
                checks++;
                if (obs_wait[i] !== exp_wait[i] || obs_rf[i] !== exp_resp[i] || obs_rl[i] !== exp_resp[i]) begin
                    errors++;
                    $display("FAIL rand_resp bus%0d beat%0d: got wait=%0d resp=%b%b want wait=%0d resp=%b", b, i, obs_wait[i], obs_rf[i], obs_rl[i], exp_wait[i], exp_resp[i]);
                end
                checks++;
                if ((exp_chk[i] && obs_data[i] !== exp_data[i]) || obs_nz[i]) begin
                    errors++;
                    $display("FAIL rand_data bus%0d beat%0d: got %h (stall nonzero=%b) want %h", b, i, obs_data[i], obs_nz[i], exp_data[i]);
                end
            end
        end
    endtask
    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_lanes();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
